// File: rtl/plab4_net_domain_outbuf.sv
// Splits one ring-network terminal output into two per-domain FIFOs.
// Each FIFO registers its entries; an empty port always shows zeros.
module plab4_net_domain_outbuf #(
  parameter int p_payload_cnbits = 32,
  parameter int p_payload_dnbits = 32,
  parameter int p_opaque_nbits   = 3,
  parameter int p_srcdest_nbits  = 3,
  parameter int p_num_entries    = 2
)(
  input  logic clk,
  input  logic reset,

  input  logic in_val,
  output logic in_rdy,
  input  logic in_domain,
  input  logic [2*p_srcdest_nbits+p_opaque_nbits+p_payload_cnbits-1:0]
               in_msg_control,
  input  logic [p_payload_dnbits-1:0] in_msg_data,

  output logic out_val_d1,
  input  logic out_rdy_d1,
  output logic [2*p_srcdest_nbits+p_opaque_nbits+p_payload_cnbits-1:0]
               out_msg_control_d1,
  output logic [p_payload_dnbits-1:0] out_msg_data_d1,

  output logic out_val_d2,
  input  logic out_rdy_d2,
  output logic [2*p_srcdest_nbits+p_opaque_nbits+p_payload_cnbits-1:0]
               out_msg_control_d2,
  output logic [p_payload_dnbits-1:0] out_msg_data_d2,

  output logic [$clog2(p_num_entries+1)-1:0] count_d1,
  output logic [$clog2(p_num_entries+1)-1:0] count_d2
);

  localparam int M  = 2*p_srcdest_nbits + p_opaque_nbits + p_payload_cnbits;
  localparam int EW = M + p_payload_dnbits;
  localparam int CW = $clog2(p_num_entries+1);
  localparam int PW = $clog2(p_num_entries);
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [EW-1:0] mem [2][p_num_entries];
  logic [PW-1:0] head [2];
  logic [PW-1:0] tail [2];
  logic [CW-1:0] cnt  [2];

  logic [1:0] full;
  logic [1:0] val;
  logic [1:0] rdy;
  logic [1:0] enq;
  logic [1:0] deq;

  logic [EW-1:0] hd1;
  logic [EW-1:0] hd2;

  assign full[0] = (cnt[0] == FULL);
  assign full[1] = (cnt[1] == FULL);

  // Readiness looks only at occupancy, never at a same-cycle dequeue.
  assign in_rdy = reset && (in_domain ? !full[1] : !full[0]);

  assign enq[0] = in_val && in_rdy && !in_domain;
  assign enq[1] = in_val && in_rdy &&  in_domain;

  assign val[0] = reset && (cnt[0] != '0);
  assign val[1] = reset && (cnt[1] != '0);
  assign rdy    = {out_rdy_d2, out_rdy_d1};
  assign deq    = val & rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        head[d] <= '0;
        tail[d] <= '0;
        cnt[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (enq[d]) tail[d] <= tail[d] + PW'(1);
        if (deq[d]) head[d] <= head[d] + PW'(1);
        unique case ({enq[d], deq[d]})
          2'b10:   cnt[d] <= cnt[d] + CW'(1);
          2'b01:   cnt[d] <= cnt[d] - CW'(1);
          default: cnt[d] <= cnt[d];
        endcase
      end
    end
  end

  // Storage is never cleared; the output mask hides stale entries.
  always_ff @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (enq[d]) mem[d][tail[d]] <= {in_msg_control, in_msg_data};
    end
  end

  assign hd1 = val[0] ? mem[0][head[0]] : '0;
  assign hd2 = val[1] ? mem[1][head[1]] : '0;

  assign out_val_d1 = val[0];
  assign out_val_d2 = val[1];
  assign {out_msg_control_d1, out_msg_data_d1} = hd1;
  assign {out_msg_control_d2, out_msg_data_d2} = hd2;

  assign count_d1 = cnt[0];
  assign count_d2 = cnt[1];

endmodule

// File: tb/tb_plab4_net_domain_outbuf.sv
// Bench for plab4_net_domain_outbuf: directed vector table plus a
// randomized mixed-domain stream against a per-domain queue model.
module tb_plab4_net_domain_outbuf;

  localparam int M = 41;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic          in_domain;
  logic [M-1:0]  in_msg_control;
  logic [31:0]   in_msg_data;
  logic          out_val_d1;
  logic          out_rdy_d1;
  logic [M-1:0]  out_msg_control_d1;
  logic [31:0]   out_msg_data_d1;
  logic          out_val_d2;
  logic          out_rdy_d2;
  logic [M-1:0]  out_msg_control_d2;
  logic [31:0]   out_msg_data_d2;
  logic [1:0]    count_d1;
  logic [1:0]    count_d2;

  plab4_net_domain_outbuf dut (
    .clk                (clk),
    .reset              (reset),
    .in_val             (in_val),
    .in_rdy             (in_rdy),
    .in_domain          (in_domain),
    .in_msg_control     (in_msg_control),
    .in_msg_data        (in_msg_data),
    .out_val_d1         (out_val_d1),
    .out_rdy_d1         (out_rdy_d1),
    .out_msg_control_d1 (out_msg_control_d1),
    .out_msg_data_d1    (out_msg_data_d1),
    .out_val_d2         (out_val_d2),
    .out_rdy_d2         (out_rdy_d2),
    .out_msg_control_d2 (out_msg_control_d2),
    .out_msg_data_d2    (out_msg_data_d2),
    .count_d1           (count_d1),
    .count_d2           (count_d2)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [M-1:0] ctrl_of(input logic [31:0] d);
    ctrl_of = {9'h1A5 ^ {1'b0, d[7:0]}, ~d};
  endfunction

  typedef struct {
    logic        rst;
    logic        val;
    logic        dom;
    logic [31:0] data;
    logic        r1;
    logic        r2;
    logic        e_rdy;
    logic        e_v1;
    logic [31:0] e_d1;
    logic [1:0]  e_c1;
    logic        e_v2;
    logic [31:0] e_d2;
    logic [1:0]  e_c2;
  } vec_t;

  vec_t tbl [16];

  task automatic drive(input logic rst, input logic v, input logic dm,
                       input logic [31:0] d, input logic r1, input logic r2);
    reset          = rst;
    in_val         = v;
    in_domain      = dm;
    in_msg_data    = d;
    in_msg_control = ctrl_of(d);
    out_rdy_d1     = r1;
    out_rdy_d2     = r2;
  endtask

  task automatic check_outs(input string tag, input logic e_rdy,
                            input logic e_v1, input logic [31:0] e_d1,
                            input logic [1:0] e_c1, input logic e_v2,
                            input logic [31:0] e_d2, input logic [1:0] e_c2);
    check({tag, " in_rdy"}, 64'(in_rdy), 64'(e_rdy));
    check({tag, " val_d1"}, 64'(out_val_d1), 64'(e_v1));
    check({tag, " data_d1"}, 64'(out_msg_data_d1), 64'(e_d1));
    check({tag, " ctrl_d1"}, 64'(out_msg_control_d1),
          64'(e_v1 ? ctrl_of(e_d1) : '0));
    check({tag, " count_d1"}, 64'(count_d1), 64'(e_c1));
    check({tag, " val_d2"}, 64'(out_val_d2), 64'(e_v2));
    check({tag, " data_d2"}, 64'(out_msg_data_d2), 64'(e_d2));
    check({tag, " ctrl_d2"}, 64'(out_msg_control_d2),
          64'(e_v2 ? ctrl_of(e_d2) : '0));
    check({tag, " count_d2"}, 64'(count_d2), 64'(e_c2));
  endtask

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  initial begin
    int pushed;
    int popped;
    logic e_rdy;
    logic [31:0] seq;

    // rst val dom data r1 r2 | rdy v1 d1 c1 v2 d2 c2 (pre-edge outputs)
    tbl[0]  = '{0,1,0,32'h0000DEAD,0,0, 0,0,32'h0,2'd0,0,32'h0,2'd0};
    tbl[1]  = '{1,1,0,32'hAAAA0001,0,0, 1,0,32'h0,2'd0,0,32'h0,2'd0};
    tbl[2]  = '{1,1,0,32'hAAAA0002,0,0,
                1,1,32'hAAAA0001,2'd1,0,32'h0,2'd0};
    tbl[3]  = '{1,1,0,32'hAAAA0003,0,0,
                0,1,32'hAAAA0001,2'd2,0,32'h0,2'd0};
    tbl[4]  = '{1,1,1,32'hBBBB0001,0,0,
                1,1,32'hAAAA0001,2'd2,0,32'h0,2'd0};
    tbl[5]  = '{1,1,0,32'hAAAA0003,1,0,
                0,1,32'hAAAA0001,2'd2,1,32'hBBBB0001,2'd1};
    tbl[6]  = '{1,1,0,32'hAAAA0004,0,0,
                1,1,32'hAAAA0002,2'd1,1,32'hBBBB0001,2'd1};
    tbl[7]  = '{0,0,0,32'h0,0,0, 0,0,32'h0,2'd2,0,32'h0,2'd1};
    tbl[8]  = '{1,0,0,32'h0,0,0, 1,0,32'h0,2'd0,0,32'h0,2'd0};
    tbl[9]  = '{1,0,1,32'h0,0,0, 1,0,32'h0,2'd0,0,32'h0,2'd0};
    tbl[10] = '{1,1,0,32'h1,1,0, 1,0,32'h0,2'd0,0,32'h0,2'd0};
    tbl[11] = '{1,1,0,32'h2,1,0, 1,1,32'h1,2'd1,0,32'h0,2'd0};
    tbl[12] = '{1,1,0,32'h3,1,0, 1,1,32'h2,2'd1,0,32'h0,2'd0};
    tbl[13] = '{1,1,0,32'h4,1,0, 1,1,32'h3,2'd1,0,32'h0,2'd0};
    tbl[14] = '{1,0,0,32'h0,1,0, 1,1,32'h4,2'd1,0,32'h0,2'd0};
    tbl[15] = '{1,0,0,32'h0,1,0, 1,0,32'h0,2'd0,0,32'h0,2'd0};

    drive(0, 0, 0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].val, tbl[i].dom, tbl[i].data,
            tbl[i].r1, tbl[i].r2);
      #2;
      check_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_v1,
                 tbl[i].e_d1, tbl[i].e_c1, tbl[i].e_v2, tbl[i].e_d2,
                 tbl[i].e_c2);
      @(posedge clk);
      #1;
    end

    // Random mixed-domain stream; the model is two bounded queues.
    pushed = 0;
    popped = 0;
    seq = 0;
    for (int c = 0; c < 400; c++) begin
      logic v;
      logic dm;
      logic [31:0] d;
      v  = ($urandom_range(0, 3) != 0);
      dm = 1'($urandom_range(0, 1));
      d  = {dm ? 16'hD2D2 : 16'hD1D1, seq[15:0]};
      drive(1, v, dm, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #2;
      e_rdy = dm ? (q2.size() < 2) : (q1.size() < 2);
      check_outs($sformatf("rnd%0d", c), e_rdy,
                 q1.size() != 0, q1.size() != 0 ? q1[0] : 32'h0,
                 2'(q1.size()),
                 q2.size() != 0, q2.size() != 0 ? q2[0] : 32'h0,
                 2'(q2.size()));
      if (out_val_d1 && out_rdy_d1) popped++;
      if (out_val_d2 && out_rdy_d2) popped++;
      if (q1.size() != 0 && out_rdy_d1) void'(q1.pop_front());
      if (q2.size() != 0 && out_rdy_d2) void'(q2.pop_front());
      if (v && e_rdy) begin
        if (dm) q2.push_back(d);
        else q1.push_back(d);
        pushed++;
        seq++;
      end
      @(posedge clk);
      #1;
    end

    // Drain everything and confirm no message was lost or duplicated.
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 32'h0, 1, 1);
      #2;
      if (out_val_d1) popped++;
      if (out_val_d2) popped++;
      @(posedge clk);
      #1;
    end
    check("drain count_d1", 64'(count_d1), 64'd0);
    check("drain count_d2", 64'(count_d2), 64'd0);
    check("delivered total", 64'(popped), 64'(pushed));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
